hop_word_seq: RTL and testbench
===============================

HOP_WORD_SEQ -- requirements
Module: hop_word_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 79: basic-hop channel count, the modulus for F.
REQ-002 SHALL have parameter CLKW, default 28: native-clock width; division width DW = CLKW-3.
REQ-003 SHALL have port clk_6M  in  1  6 MHz clock, rising-edge.
REQ-004 SHALL have port rstz  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_p  in  1  one-cycle request to compute a new hop word.
REQ-006 SHALL have port flush_p  in  1  one-cycle abort of any computation in progress.
REQ-007 SHALL have port clk_in  in  CLKW  piconet clock CLK.
REQ-008 SHALL have port afh_n  in  7  AFH used-channel count N.
REQ-009 SHALL have port afh_mode  in  1  AFH enabled.
REQ-010 SHALL have port conns  in  1  connection state active.
REQ-011 SHALL have port busy  out  1  computation in progress.
REQ-012 SHALL have port valid_p  out  1  one-cycle pulse when the outputs update.
REQ-013 SHALL have port F, Fprime  out  7 each  hop offsets.
REQ-014 SHALL have port X  out  5  registered copy of latched CLK[6:2].
REQ-015 SHALL have port Y1  out  1  latched CLK[1] & !afh_mode.
REQ-016 SHALL have port Y2  out  6  {Y1, 5'b0}.
REQ-017 SHALL have port n_err  out  1  latched afh_n was 0 or greater than NUM_CH.

Function
REQ-018 FSM states SHALL be IDLE, DIV_F, DIV_FP, DONE; IDLE on reset.
REQ-019 In IDLE, start_p SHALL latch clk_in, afh_n and afh_mode, assert busy next cycle, and enter DIV_F.
REQ-020 Dividend SHALL be {clk_in[CLKW-1:7], 4'b0}, DW bits wide, i.e. 16*CLK[CLKW-1:7].
REQ-021 DIV_F SHALL compute dividend mod NUM_CH by restoring division, one quotient bit per cycle, MSB first, DW cycles.
REQ-022 DIV_FP SHALL compute dividend mod latched afh_n by the same method in DW cycles.
REQ-023 DONE SHALL last one cycle: register F, Fprime, X, Y1, Y2 and n_err, pulse valid_p, deassert busy, and return to IDLE.
REQ-024 Latency SHALL be: start_p at cycle 0 gives valid_p at cycle 2*DW+2 (52 for defaults).
REQ-025 F and Fprime SHALL be forced to 0 when the latched conns is 0, and the partial remainder SHALL stay below the modulus (7-bit arithmetic).
REQ-026 If latched afh_n is 0 or greater than NUM_CH, DIV_FP SHALL still take DW cycles, Fprime SHALL be 0, and n_err SHALL be 1.
REQ-027 start_p while busy SHALL be ignored; no queueing.
REQ-028 flush_p SHALL return the FSM to IDLE next cycle with no valid_p and outputs unchanged.
REQ-029 When flush_p and start_p arrive in the same cycle, flush_p SHALL win and start_p SHALL be dropped.
REQ-030 Outputs SHALL hold their values between valid_p pulses, and clk_in changes during busy SHALL have no effect.

Reset
REQ-031 rstz low SHALL asynchronously force state IDLE, busy=0, valid_p=0, F=0, Fprime=0, X=0, Y1=0, Y2=0, n_err=0, and clear all latches and remainders.
REQ-032 Reset asserted mid-computation SHALL discard the result, and no valid_p SHALL follow reset release.

Configuration
REQ-033 Macro HOPWD_PARALLEL_DIV_EN defined: two dividers SHALL run concurrently in a single DIV state (DIV_FP skipped), giving valid_p at cycle DW+2 (27 for defaults).
REQ-034 Macro undefined: one shared divider datapath SHALL be used sequentially per REQ-021 to REQ-024.

Verification
REQ-035 clk_in=0, afh_n=79, conns=1, start_p -> valid_p at cycle 52, F=0, Fprime=0, X=0, Y1=0, n_err=0.
REQ-036 clk_in=28'h0000286 (CLK[27:7]=5, CLK[6:2]=1, CLK[1]=1), afh_n=20, afh_mode=0 -> F=1, Fprime=0, X=1, Y1=1, Y2=6'h20.
REQ-037 clk_in=28'hFFFFFFF, afh_n=79, afh_mode=1 -> F=35, Fprime=35, X=31, Y1=0.
REQ-038 afh_n=0 then afh_n=80 -> each gives n_err=1 and Fprime=0; conns=0 gives F=0.
REQ-039 flush_p at cycle 10, then start_p at cycle 11 while busy, then start_p together with flush_p -> no valid_p, and the next start_p gives correct results.
REQ-040 rstz pulsed low at cycle 30 of a computation -> all outputs 0 and no valid_p. With HOPWD_PARALLEL_DIV_EN, REQ-036 stimulus gives the same values with valid_p at cycle 27.

Source files
------------

// File: rtl/hop_word_seq_if.sv
// Bundle of request, piconet-clock inputs and hop-word results for hop_word_seq.
// master drives requests and samples results; slave is the hop-word sequencer.
interface hop_word_seq_if #(
  parameter int CLKW = 28
);
  logic            start_p;
  logic            flush_p;
  logic [CLKW-1:0] clk_in;
  logic [6:0]      afh_n;
  logic            afh_mode;
  logic            conns;
  logic            busy;
  logic            valid_p;
  logic [6:0]      F;
  logic [6:0]      Fprime;
  logic [4:0]      X;
  logic            Y1;
  logic [5:0]      Y2;
  logic            n_err;

  modport master (
    output start_p, flush_p, clk_in, afh_n, afh_mode, conns,
    input  busy, valid_p, F, Fprime, X, Y1, Y2, n_err
  );

  modport slave (
    input  start_p, flush_p, clk_in, afh_n, afh_mode, conns,
    output busy, valid_p, F, Fprime, X, Y1, Y2, n_err
  );
endinterface

// File: rtl/hop_word_seq.sv
// Hop-word sequencer: computes 16*CLK[CLKW-1:7] mod NUM_CH and mod afh_n by restoring division.
// Define HOPWD_PARALLEL_DIV_EN to run both divisions concurrently; default shares one divider.
module hop_word_seq #(
  parameter int NUM_CH = 79,
  parameter int CLKW   = 28
) (
  input  logic          clk_6M,
  input  logic          rstz,
  hop_word_seq_if.slave hw
);
  localparam int DW = CLKW - 3;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);
  localparam logic [6:0]    NCH      = 7'(NUM_CH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIV_F  = 2'd1;
  localparam logic [1:0] DIV_FP = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   bit_cnt;
  logic [CLKW-1:0] clk_l;
  logic [6:0]      n_l;
  logic            mode_l;
  logic            conns_l;
  logic [DW-1:0]   dvd;
  logic [6:0]      rem_a;
  logic [6:0]      rem_b;
  logic [6:0]      step_a;
  logic [6:0]      step_b;
  logic            n_bad;
  logic [6:0]      mod_fp;

  logic            busy_r;
  logic            valid_r;
  logic [6:0]      f_r;
  logic [6:0]      fp_r;
  logic [4:0]      x_r;
  logic            y1_r;
  logic [5:0]      y2_r;
  logic            nerr_r;

  // One restoring-division step; the partial remainder stays below m, so 8 bits suffice.
  function automatic logic [6:0] div_step(input logic [6:0] r, input logic b, input logic [6:0] m);
    logic [7:0] t;
    t = {r, b};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[6:0];
  endfunction

  function automatic logic [DW-1:0] make_dvd(input logic [CLKW-1:0] c);
    return {c[CLKW-1:7], 4'b0};
  endfunction

  // An invalid N divides by 1 so the remainder path stays at 0 for the full DW cycles.
  assign n_bad  = (n_l == 7'd0) || (n_l > NCH);
  assign mod_fp = n_bad ? 7'd1 : n_l;

`ifdef HOPWD_PARALLEL_DIV_EN
  assign step_a = div_step(rem_a, dvd[DW-1], NCH);
  assign step_b = div_step(rem_b, dvd[DW-1], mod_fp);
`else
  logic in_fp;
  assign in_fp  = (state == DIV_FP);
  assign step_a = div_step(in_fp ? rem_b : rem_a, dvd[DW-1], in_fp ? mod_fp : NCH);
  assign step_b = step_a;
`endif

  // CLK[0] never contributes to the hop word.
  logic unused_clk0;
  assign unused_clk0 = clk_l[0];

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state   <= IDLE;
      bit_cnt <= '0;
      clk_l   <= '0;
      n_l     <= '0;
      mode_l  <= 1'b0;
      conns_l <= 1'b0;
      dvd     <= '0;
      rem_a   <= '0;
      rem_b   <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      f_r     <= '0;
      fp_r    <= '0;
      x_r     <= '0;
      y1_r    <= 1'b0;
      y2_r    <= '0;
      nerr_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (hw.flush_p) begin
        state   <= IDLE;
        busy_r  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (hw.start_p) begin
              clk_l   <= hw.clk_in;
              n_l     <= hw.afh_n;
              mode_l  <= hw.afh_mode;
              conns_l <= hw.conns;
              dvd     <= make_dvd(hw.clk_in);
              rem_a   <= '0;
              rem_b   <= '0;
              bit_cnt <= '0;
              busy_r  <= 1'b1;
              state   <= DIV_F;
            end
          end
          DIV_F: begin
            dvd     <= dvd << 1;
            rem_a   <= step_a;
`ifdef HOPWD_PARALLEL_DIV_EN
            rem_b   <= step_b;
`endif
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef HOPWD_PARALLEL_DIV_EN
              state   <= DONE;
`else
              dvd     <= make_dvd(clk_l);
              state   <= DIV_FP;
`endif
            end
          end
          DIV_FP: begin
            dvd     <= dvd << 1;
            rem_b   <= step_b;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= DONE;
            end
          end
          default: begin
            f_r     <= conns_l ? rem_a : 7'd0;
            fp_r    <= (conns_l && !n_bad) ? rem_b : 7'd0;
            x_r     <= clk_l[6:2];
            y1_r    <= clk_l[1] & ~mode_l;
            y2_r    <= {clk_l[1] & ~mode_l, 5'b0};
            nerr_r  <= n_bad;
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

  assign hw.busy    = busy_r;
  assign hw.valid_p = valid_r;
  assign hw.F       = f_r;
  assign hw.Fprime  = fp_r;
  assign hw.X       = x_r;
  assign hw.Y1      = y1_r;
  assign hw.Y2      = y2_r;
  assign hw.n_err   = nerr_r;
endmodule

// File: tb/tb_hop_word_seq.sv
// Directed and randomized bench for hop_word_seq against an arithmetic reference model.
module tb_hop_word_seq;
  localparam int NUM_CH = 79;
  localparam int CLKW   = 28;
  localparam int DW     = CLKW - 3;
`ifdef HOPWD_PARALLEL_DIV_EN
  localparam int LAT = DW + 2;
`else
  localparam int LAT = 2 * DW + 2;
`endif

  logic clk_6M = 1'b0;
  logic rstz   = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  logic [6:0] hold_f, hold_fp;
  logic [4:0] hold_x;
  logic       hold_y1, hold_nerr;

  hop_word_seq_if #(.CLKW(CLKW)) hw ();

  hop_word_seq #(.NUM_CH(NUM_CH), .CLKW(CLKW)) dut (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .hw     (hw)
  );

  always #83 clk_6M = ~clk_6M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_F"},  32'(hw.F),      32'(hold_f));
    chk({tag, "_FP"}, 32'(hw.Fprime), 32'(hold_fp));
    chk({tag, "_X"},  32'(hw.X),      32'(hold_x));
    chk({tag, "_Y1"}, 32'(hw.Y1),     32'(hold_y1));
    chk({tag, "_NE"}, 32'(hw.n_err),  32'(hold_nerr));
  endtask

  // Full transaction: a stray start_p with different inputs is injected mid-run and must be ignored.
  task automatic run(input string tag, input logic [CLKW-1:0] c, input logic [6:0] n,
                     input logic m, input logic cn);
    longint d;
    int     cyc;
    logic   nerr;
    d    = longint'(c >> 7) * 16;
    nerr = (n == 0) || (n > NUM_CH);
    @(posedge clk_6M); #1;
    hw.clk_in = c; hw.afh_n = n; hw.afh_mode = m; hw.conns = cn; hw.start_p = 1'b1;
    @(posedge clk_6M); #1;
    hw.start_p = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, 32'(hw.busy), 32'd1);
    while (hw.valid_p !== 1'b1 && cyc < 200) begin
      if (cyc == 3) begin
        hw.start_p = 1'b1; hw.clk_in = CLKW'($urandom); hw.afh_n = 7'($urandom);
        hw.afh_mode = ~m; hw.conns = ~cn;
      end else begin
        hw.start_p = 1'b0;
      end
      @(posedge clk_6M); #1;
      cyc++;
    end
    hold_f    = cn ? 7'(d % NUM_CH) : 7'd0;
    hold_fp   = (cn && !nerr) ? 7'(d % longint'(n)) : 7'd0;
    hold_x    = c[6:2];
    hold_y1   = c[1] & ~m;
    hold_nerr = nerr;
    chk({tag, "_lat"}, 32'(cyc), 32'(LAT));
    chk_hold(tag);
    chk({tag, "_Y2"}, 32'(hw.Y2), 32'({hold_y1, 5'b0}));
    @(posedge clk_6M); #1;
    chk({tag, "_pulse"}, 32'(hw.valid_p), 32'd0);
    chk({tag, "_idle"},  32'(hw.busy),    32'd0);
    chk_hold({tag, "_hold"});
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_6M); #1;
      if (hw.valid_p === 1'b1) seen++;
    end
    chk({tag, "_novalid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    hw.start_p = 1'b0; hw.flush_p = 1'b0; hw.clk_in = '0;
    hw.afh_n = 7'd79; hw.afh_mode = 1'b0; hw.conns = 1'b1;
    hold_f = '0; hold_fp = '0; hold_x = '0; hold_y1 = 1'b0; hold_nerr = 1'b0;
    #1;
    chk("rst_busy",  32'(hw.busy),    32'd0);
    chk("rst_valid", 32'(hw.valid_p), 32'd0);
    chk("rst_Y2",    32'(hw.Y2),      32'd0);
    chk_hold("rst");
    repeat (3) @(posedge clk_6M);
    #1 rstz = 1'b1;

    run("zero",  28'h0000000, 7'd79, 1'b0, 1'b1);
    run("c286",  28'h0000286, 7'd20, 1'b0, 1'b1);
    run("ones",  28'hFFFFFFF, 7'd79, 1'b1, 1'b1);
    run("n0",    28'h1234567, 7'd0,  1'b0, 1'b1);
    run("n80",   28'h1234567, 7'd80, 1'b1, 1'b1);
    run("nocon", 28'hABCDEF1, 7'd33, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      logic [6:0] rn;
      rn = (k % 4 == 3) ? 7'($urandom) : 7'($urandom_range(1, NUM_CH));
      run("rand", CLKW'($urandom), rn, 1'($urandom), ($urandom_range(0, 4) != 0));
    end

    // Abort mid-division, then a simultaneous flush/start that must be dropped.
    @(posedge clk_6M); #1;
    hw.clk_in = 28'h7654321; hw.afh_n = 7'd50; hw.start_p = 1'b1;
    @(posedge clk_6M); #1;
    hw.start_p = 1'b0;
    repeat (9) @(posedge clk_6M);
    #1 hw.flush_p = 1'b1;
    @(posedge clk_6M); #1;
    hw.flush_p = 1'b0;
    chk("flush_busy", 32'(hw.busy), 32'd0);
    chk_hold("flush");
    hw.start_p = 1'b1; hw.flush_p = 1'b1;
    @(posedge clk_6M); #1;
    hw.start_p = 1'b0; hw.flush_p = 1'b0;
    chk("both_busy", 32'(hw.busy), 32'd0);
    watch_no_valid("flush", LAT + 10);
    chk_hold("flush_after");
    run("postflush", 28'h0000286, 7'd20, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a computation.
    @(posedge clk_6M); #1;
    hw.clk_in = 28'hFFFFFFF; hw.afh_n = 7'd79; hw.afh_mode = 1'b1; hw.start_p = 1'b1;
    @(posedge clk_6M); #1;
    hw.start_p = 1'b0;
    repeat (29) @(posedge clk_6M);
    #20 rstz = 1'b0;
    #1;
    hold_f = '0; hold_fp = '0; hold_x = '0; hold_y1 = 1'b0; hold_nerr = 1'b0;
    chk("mrst_busy", 32'(hw.busy), 32'd0);
    chk("mrst_Y2",   32'(hw.Y2),   32'd0);
    chk_hold("mrst");
    @(posedge clk_6M); #1;
    rstz = 1'b1;
    watch_no_valid("mrst", LAT + 10);
    chk_hold("mrst_after");
    run("postrst", 28'hFFFFFFF, 7'd79, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
